// File: rtl/mc_controlunit.sv
// mc_controlunit: multicycle MIPS control FSM (IF/ID/EX/MEM/WB) with memory-ready stalls and illegal-op trap.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_op, i_func            IR[31:26], IR[5:0]; latched in ID
//   i_zero                  ALU zero flag, used by beq/bne in EX
//   i_mem_ready             memory access complete (IF fetch, MEM load/store)
//   o_state                 IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=7
//   o_pc_wr, o_ir_wr        PC / IR load enables
//   o_mem_rd, o_mem_wr      memory read / write requests
//   o_aluc, o_alusrcb       ALU operation, B operand select (1 = immediate)
//   o_shift, o_sext         A operand = shamt, sign-extend immediate
//   o_regdst, o_mem2reg     write address / write data selects
//   o_wrf                   register-file write enable
//   o_pcsource              next-PC select
//   o_illegal               one-cycle pulse in ID on an undecodable instruction
module mc_controlunit #(
  parameter bit ITYPE_EN  = 1'b1,
  parameter bit TRAP_HALT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic [2:0] o_state,
  output logic       o_pc_wr,
  output logic       o_ir_wr,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic [3:0] o_aluc,
  output logic       o_alusrcb,
  output logic       o_shift,
  output logic       o_sext,
  output logic [1:0] o_regdst,
  output logic [1:0] o_mem2reg,
  output logic       o_wrf,
  output logic [1:0] o_pcsource,
  output logic       o_illegal
);
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7
  } state_t;
  typedef enum logic [3:0] {
    C_ILL, C_RALU, C_JR, C_IALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL
  } cls_t;
  state_t     r_state;
  logic [5:0] r_op, r_func;
  logic [5:0] w_op, w_func;
  cls_t       w_cls;
  logic [3:0] w_aluc;
  logic       w_shift, w_sext;
  // ID decodes the live IR fields; every later state uses the copy latched on leaving ID
  assign w_op   = r_state == S_ID ? i_op : r_op;
  assign w_func = r_state == S_ID ? i_func : r_func;
  always_comb begin
    w_cls   = C_ILL;
    w_aluc  = 4'b0000;
    w_shift = 1'b0;
    w_sext  = 1'b0;
    if (w_op == 6'b000000) begin
      w_cls = C_RALU;
      case (w_func)
        6'b100000: w_aluc = 4'b0010;
        6'b100001: w_aluc = 4'b0000;
        6'b100010: w_aluc = 4'b0011;
        6'b100011: w_aluc = 4'b0001;
        6'b100100: w_aluc = 4'b0100;
        6'b100101: w_aluc = 4'b0101;
        6'b100110: w_aluc = 4'b0110;
        6'b100111: w_aluc = 4'b0111;
        6'b101010: w_aluc = 4'b1011;
        6'b101011: w_aluc = 4'b1010;
        6'b000000: begin w_aluc = 4'b1110; w_shift = 1'b1; end
        6'b000010: begin w_aluc = 4'b1101; w_shift = 1'b1; end
        6'b000011: begin w_aluc = 4'b1100; w_shift = 1'b1; end
        6'b000100: w_aluc = 4'b1110;
        6'b000110: w_aluc = 4'b1101;
        6'b000111: w_aluc = 4'b1100;
        6'b001000: w_cls = C_JR;
        default:   w_cls = C_ILL;
      endcase
    end else if (ITYPE_EN) begin
      case (w_op)
        6'b001000: begin w_cls = C_IALU; w_aluc = 4'b0010; w_sext = 1'b1; end
        6'b001100: begin w_cls = C_IALU; w_aluc = 4'b0100; end
        6'b001101: begin w_cls = C_IALU; w_aluc = 4'b0101; end
        6'b001110: begin w_cls = C_IALU; w_aluc = 4'b0110; end
        6'b001111: begin w_cls = C_IALU; w_aluc = 4'b1000; end
        6'b001010: begin w_cls = C_IALU; w_aluc = 4'b1011; w_sext = 1'b1; end
        6'b100011: begin w_cls = C_LW;   w_sext = 1'b1; end
        6'b101011: begin w_cls = C_SW;   w_sext = 1'b1; end
        6'b000100: begin w_cls = C_BEQ;  w_aluc = 4'b0001; w_sext = 1'b1; end
        6'b000101: begin w_cls = C_BNE;  w_aluc = 4'b0001; w_sext = 1'b1; end
        6'b000010: w_cls = C_J;
        6'b000011: w_cls = C_JAL;
        default:   w_cls = C_ILL;
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IF;
      r_op    <= 6'b0;
      r_func  <= 6'b0;
    end else begin
      case (r_state)
        S_IF:  if (i_mem_ready) r_state <= S_ID;
        S_ID: begin
          r_op    <= i_op;
          r_func  <= i_func;
          r_state <= w_cls == C_ILL ? (TRAP_HALT ? S_HALT : S_IF) : S_EX;
        end
        S_EX:  r_state <= (w_cls == C_RALU || w_cls == C_IALU || w_cls == C_JAL) ? S_WB :
                          (w_cls == C_LW || w_cls == C_SW) ? S_MEM : S_IF;
        S_MEM: if (i_mem_ready) r_state <= w_cls == C_LW ? S_WB : S_IF;
        S_WB:  r_state <= S_IF;
        default: r_state <= S_HALT;
      endcase
    end
  end
  assign o_state = r_state;
  // strobes are gated by rst_n so that everything reads 0 while reset is held, including mem_rd in IF
  always_comb begin
    o_pc_wr    = 1'b0;
    o_ir_wr    = 1'b0;
    o_mem_rd   = 1'b0;
    o_mem_wr   = 1'b0;
    o_aluc     = 4'b0000;
    o_alusrcb  = 1'b0;
    o_shift    = 1'b0;
    o_sext     = 1'b0;
    o_regdst   = 2'b00;
    o_mem2reg  = 2'b00;
    o_wrf      = 1'b0;
    o_pcsource = 2'b00;
    o_illegal  = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        S_IF: begin
          o_mem_rd = 1'b1;
          o_pc_wr  = i_mem_ready;
          o_ir_wr  = i_mem_ready;
        end
        S_ID: o_illegal = w_cls == C_ILL;
        S_EX: begin
          o_aluc     = w_aluc;
          o_alusrcb  = w_cls == C_IALU || w_cls == C_LW || w_cls == C_SW;
          o_shift    = w_shift;
          o_sext     = w_sext;
          o_pc_wr    = w_cls == C_JR || w_cls == C_J || w_cls == C_JAL ||
                       (w_cls == C_BEQ && i_zero) || (w_cls == C_BNE && !i_zero);
          o_pcsource = w_cls == C_JR ? 2'b01 :
                       (w_cls == C_J || w_cls == C_JAL) ? 2'b11 :
                       (w_cls == C_BEQ || w_cls == C_BNE) ? 2'b10 : 2'b00;
        end
        S_MEM: begin
          o_mem_rd = w_cls == C_LW;
          o_mem_wr = w_cls == C_SW;
        end
        S_WB: begin
          o_wrf     = 1'b1;
          o_regdst  = w_cls == C_JAL ? 2'b10 : (w_cls == C_IALU || w_cls == C_LW) ? 2'b01 : 2'b00;
          o_mem2reg = w_cls == C_JAL ? 2'b10 : w_cls == C_LW ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end
endmodule
